// File: rtl/alu_apb_slave.sv
// APB3 register front-end for the 16-bit add/subtract ALU.
// Holds operands and control, sequences one ALU operation per START, captures RESULT.
module alu_apb_slave #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [15:0] pwdata,
    output logic [15:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        alu_enable,
    output logic        alu_control,
    input  logic [15:0] alu_output
);

    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LATENCY - 1);

    localparam logic [1:0] SEL_OPA  = 2'd0;
    localparam logic [1:0] SEL_OPB  = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;
    localparam logic [1:0] SEL_RES  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAPT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [15:0]   opa;
    logic [15:0]   opb;
    logic [15:0]   result;
    logic          op;
    logic          done;
    logic          run_en;
    logic          capture;

    logic       access;
    logic [1:0] sel;
    logic       err;
    logic       busy;
    logic       stall;
    logic       xfer;
    logic       wr;
    logic       rd;
    logic       start;

    assign access = psel & penable;
    assign sel    = paddr[3:2];
    assign busy   = (state != S_IDLE);

    // Errors are decided first so they are never stalled and have no effect.
    assign err   = access & ((|paddr[1:0]) | (pwrite & (sel == SEL_RES)));
    assign stall = access & pwrite & ~err & busy;
    assign xfer  = access & ~err & ~stall;
    assign wr    = xfer & pwrite;
    assign rd    = xfer & ~pwrite;
    assign start = wr & (sel == SEL_CTRL) & pwdata[1];

    assign pready  = ~stall;
    assign pslverr = err;

    assign A           = opa;
    assign B           = opb;
    assign alu_control = op;
    assign alu_enable  = run_en;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_en    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                run_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                capture   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_RUN) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            opa <= '0;
            opb <= '0;
            op  <= 1'b0;
        end else if (wr) begin
            if (sel == SEL_OPA) begin
                opa <= pwdata;
            end
            if (sel == SEL_OPB) begin
                opb <= pwdata;
            end
            if (sel == SEL_CTRL) begin
                op <= pwdata[0];
            end
        end
    end

    // A capture on the same edge as a RESULT read leaves DONE set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            result <= '0;
            done   <= 1'b0;
        end else if (capture) begin
            result <= alu_output;
            done   <= 1'b1;
        end else if (start || (rd && (sel == SEL_RES))) begin
            done <= 1'b0;
        end
    end

    always_comb begin
        prdata = '0;
        if (access && !err) begin
            unique case (sel)
                SEL_OPA:  prdata = opa;
                SEL_OPB:  prdata = opb;
                SEL_CTRL: prdata = {12'h000, done, busy, 1'b0, op};
                SEL_RES:  prdata = result;
                default:  prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_apb_slave.sv
// Randomized self-checking bench for alu_apb_slave.
// Includes a registered ALU stand-in and a plain-arithmetic reference model.
module tb_alu_apb_slave;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        nreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] A;
    logic [15:0] B;
    logic        alu_enable;
    logic        alu_control;
    logic [15:0] alu_q;

    int n_chk  = 0;
    int n_fail = 0;

    alu_apb_slave #(.ALU_LATENCY(LAT)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .A           (A),
        .B           (B),
        .alu_enable  (alu_enable),
        .alu_control (alu_control),
        .alu_output  (alu_q)
    );

    always #5 clk = ~clk;

    // Registered ALU stand-in.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            alu_q <= '0;
        end else if (alu_enable) begin
            alu_q <= alu_control ? (A - B) : (A + B);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input int a, input int b,
                                            input bit sub);
        int r;
        r = sub ? (a - b) : (a + b);
        r = ((r % 65536) + 65536) % 65536;
        return 16'(r);
    endfunction

    task automatic apb_xfer(input logic wr, input logic [3:0] a,
                            input logic [15:0] d, output logic [15:0] q,
                            output int waits, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge clk);
        #1 penable = 1'b1;
        #1;
        waits = 0;
        while (!pready && waits < 50) begin
            @(posedge clk);
            #2;
            waits++;
        end
        q   = prdata;
        err = pslverr;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr_ok(input string tag, input logic [3:0] a,
                         input logic [15:0] d);
        logic [15:0] q;
        int          w;
        logic        e;
        apb_xfer(1'b1, a, d, q, w, e);
        check({tag, "_wait"}, w, 0);
        check({tag, "_err"}, e, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [15:0] exp);
        logic [15:0] q;
        int          w;
        logic        e;
        apb_xfer(1'b0, a, 16'h0, q, w, e);
        check(tag, q, exp);
        check({tag, "_wait"}, w, 0);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input bit sub);
        logic [15:0] q;
        int          w;
        logic        e;
        int          polls;
        wr_ok({tag, "_opa"}, 4'h0, a);
        wr_ok({tag, "_opb"}, 4'h4, b);
        wr_ok({tag, "_ctrl"}, 4'h8, {14'h0, 1'b1, sub});
        check({tag, "_A"}, A, a);
        check({tag, "_B"}, B, b);
        check({tag, "_op"}, alu_control, sub);
        polls = 0;
        q     = '0;
        while (!q[3] && polls < 10) begin
            apb_xfer(1'b0, 4'h8, 16'h0, q, w, e);
            polls++;
        end
        check({tag, "_done"}, q[3], 1'b1);
        rd_chk({tag, "_res"}, 4'hC, ref_alu(int'(a), int'(b), sub));
        rd_chk({tag, "_ctrl_after"}, 4'h8, {15'h0, sub});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        int          w;
        logic        e;
        logic [15:0] ra;
        logic [15:0] rb;
        bit          rs;

        nreset  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset between edges with non-zero state.
        wr_ok("pre_opa", 4'h0, 16'h1234);
        wr_ok("pre_opb", 4'h4, 16'h0FF0);
        wr_ok("pre_ctrl", 4'h8, 16'h0001);
        check("pre_A", A, 16'h1234);
        check("pre_op", alu_control, 1'b1);
        #3 nreset = 1'b0;
        #1;
        check("rst_A", A, 16'h0);
        check("rst_B", B, 16'h0);
        check("rst_op", alu_control, 1'b0);
        check("rst_en", alu_enable, 1'b0);
        check("rst_prdata", prdata, 16'h0);
        check("rst_pready", pready, 1'b1);
        check("rst_pslverr", pslverr, 1'b0);
        @(posedge clk);
        #1 nreset = 1'b1;
        rd_chk("rst_ctrl", 4'h8, 16'h0000);
        rd_chk("rst_opa", 4'h0, 16'h0000);
        rd_chk("rst_res", 4'hC, 16'h0000);

        // Add, with a RESULT read completing on the capture edge.
        wr_ok("add_opa", 4'h0, 16'h1234);
        wr_ok("add_opb", 4'h4, 16'h0FF0);
        wr_ok("add_ctrl", 4'h8, 16'h0002);
        check("add_en_e0", alu_enable, 1'b1);
        rd_chk("add_res_old", 4'hC, 16'h0000);
        rd_chk("add_ctrl_done", 4'h8, 16'h0008);
        rd_chk("add_res", 4'hC, 16'h2224);
        rd_chk("add_ctrl_clr", 4'h8, 16'h0000);

        // Subtract with wrap; exact enable and done timing.
        wr_ok("sub_opa", 4'h0, 16'h0005);
        wr_ok("sub_opb", 4'h4, 16'h0007);
        wr_ok("sub_ctrl", 4'h8, 16'h0003);
        check("sub_en_e0", alu_enable, 1'b1);
        @(posedge clk);
        #1 check("sub_en_e1", alu_enable, 1'b0);
        @(posedge clk);
        #1;
        rd_chk("sub_ctrl_done", 4'h8, 16'h0009);
        rd_chk("sub_res", 4'hC, 16'hFFFE);

        do_op("ovf", 16'hFFFF, 16'h0002, 1'b0);

        // Write during busy stalls and commits after the capture.
        wr_ok("stl_opa", 4'h0, 16'h1111);
        wr_ok("stl_opb", 4'h4, 16'h0001);
        wr_ok("stl_ctrl", 4'h8, 16'h0002);
        apb_xfer(1'b1, 4'h0, 16'hAAAA, q, w, e);
        check("stl_wait", w, LAT);
        check("stl_err", e, 1'b0);
        rd_chk("stl_res", 4'hC, 16'h1112);
        rd_chk("stl_opa_new", 4'h0, 16'hAAAA);

        // CTRL poll while busy completes with no wait states.
        wr_ok("bsy_ctrl", 4'h8, 16'h0002);
        apb_xfer(1'b0, 4'h8, 16'h0, q, w, e);
        check("bsy_ctrl_rd", q, 16'h0004);
        check("bsy_wait", w, 0);
        rd_chk("bsy_done", 4'h8, 16'h0008);
        rd_chk("bsy_res", 4'hC, 16'hAAAB);

        // Error responses.
        apb_xfer(1'b1, 4'hC, 16'h5555, q, w, e);
        check("err_wc_err", e, 1'b1);
        check("err_wc_wait", w, 0);
        rd_chk("err_wc_res", 4'hC, 16'hAAAB);
        apb_xfer(1'b1, 4'h2, 16'h7777, q, w, e);
        check("err_w2_err", e, 1'b1);
        rd_chk("err_w2_opa", 4'h0, 16'hAAAA);
        rd_chk("err_w2_opb", 4'h4, 16'h0001);
        apb_xfer(1'b0, 4'h2, 16'h0, q, w, e);
        check("err_r2_err", e, 1'b1);
        check("err_r2_data", q, 16'h0000);
        apb_xfer(1'b1, 4'h9, 16'h0003, q, w, e);
        check("err_w9_err", e, 1'b1);
        check("err_w9_en", alu_enable, 1'b0);
        rd_chk("err_w9_ctrl", 4'h8, 16'h0000);

        // An error during busy is answered without stalling.
        wr_ok("ebsy_ctrl", 4'h8, 16'h0002);
        apb_xfer(1'b1, 4'hC, 16'h1234, q, w, e);
        check("ebsy_wait", w, 0);
        check("ebsy_err", e, 1'b1);
        rd_chk("ebsy_ctrl", 4'h8, 16'h0008);
        rd_chk("ebsy_res", 4'hC, 16'hAAAB);

        // Reset while the ALU is enabled.
        wr_ok("mrst_ctrl", 4'h8, 16'h0002);
        check("mrst_en_hi", alu_enable, 1'b1);
        #2 nreset = 1'b0;
        #1 check("mrst_en_lo", alu_enable, 1'b0);
        @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("mrst_res", 4'hC, 16'h0000);
        rd_chk("mrst_ctrl", 4'h8, 16'h0000);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
